// File: rtl/dsp_pkg.sv
// Shared definitions for the receive DSP chain.
//   MULT_W / MULT_LAT : multiplier product width and pipeline latency; the
//                       driver delays valid/last by MULT_LAT to align them.
//   DEF_OUT_W / DEF_SHIFT : default result width and Q17 rescale shift.
//   sat_add(a, b, w)  : signed add clamped to a w-bit two's complement range,
//                       returning the clamped sum and an overflow bit.
package dsp_pkg;

   localparam int unsigned MULT_W    = 36;
   localparam int unsigned MULT_LAT  = 2;
   localparam int unsigned DEF_OUT_W = 18;
   localparam int unsigned DEF_SHIFT = 17;
   localparam int unsigned SAT_W     = 64;

   typedef struct packed {
      logic signed [SAT_W-1:0] sum;
      logic                    ovf;
   } sat_res_t;

   // Operands are sign-extended w-bit values; with w < SAT_W the 64-bit add
   // is exact, so comparing it against the w-bit limits is equivalent to the
   // operand-sign overflow rule and picks the correct clamp direction.
   function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                        input logic signed [SAT_W-1:0] b,
                                        input int unsigned             w);
      logic signed [SAT_W-1:0] mx;
      logic signed [SAT_W-1:0] mn;
      logic signed [SAT_W-1:0] s;
      sat_res_t                res;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn = -mx - 64'sd1;
      s  = a + b;
      res.ovf = (s > mx) || (s < mn);
      if (s > mx)
         res.sum = mx;
      else if (s < mn)
         res.sum = mn;
      else
         res.sum = s;
      return res;
   endfunction

endpackage

// File: rtl/round_sat.sv
// Registered round-half-up, arithmetic right shift and clamp of a frame sum.
//   clk, rst  : clock, synchronous active-high reset
//   hold      : ACC_W-bit signed frame sum
//   hold_ovf  : accumulator saturated during that frame
//   dump      : hold/hold_ovf are new this cycle; produce a result next edge
//   y         : OUT_W-bit signed result, holds between updates
//   y_valid   : one-cycle pulse when y updates
//   y_sat     : result clamped or accumulator saturated, valid with y_valid
module round_sat #(
   parameter int unsigned ACC_W = 40,
   parameter int unsigned SHIFT = 17,
   parameter int unsigned OUT_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ACC_W-1:0] hold,
   input  logic             hold_ovf,
   input  logic             dump,
   output logic [OUT_W-1:0] y,
   output logic             y_valid,
   output logic             y_sat
);

   localparam logic signed [ACC_W:0] RND  = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W:0] pre;
   logic signed [ACC_W:0] r;
   logic                  hi;
   logic                  lo;

   // One extra bit so the rounding pre-add cannot wrap near +full-scale.
   always_comb begin
      pre = $signed({hold[ACC_W-1], hold}) + RND;
      r   = pre >>> SHIFT;
      hi  = r > MAXV;
      lo  = r < MINV;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y       <= '0;
         y_valid <= 1'b0;
         y_sat   <= 1'b0;
      end else begin
         y_valid <= dump;
         if (dump) begin
            if (hi)
               y <= MAXV[OUT_W-1:0];
            else if (lo)
               y <= MINV[OUT_W-1:0];
            else
               y <= r[OUT_W-1:0];
            y_sat <= hold_ovf | hi | lo;
         end
      end
   end

endmodule

// File: rtl/mult_product_accum.sv
// Frame accumulator for the signed multiplier product stream.
// Products are summed with saturation until p_last; the frame sum is then
// rounded, shifted and clamped by round_sat into one result per frame.
//   clk, rst : clock, synchronous active-high reset
//   p_valid  : product on p is valid (aligned to multiplier latency)
//   p_last   : final product of a frame, qualified by p_valid
//   p        : P_W-bit signed product
//   y        : OUT_W-bit signed frame result, holds between updates
//   y_valid  : one-cycle pulse when y updates
//   y_sat    : output clamp or accumulator saturation hit this frame
module mult_product_accum
   import dsp_pkg::*;
#(
   parameter int unsigned P_W   = MULT_W,
   parameter int unsigned ACC_W = 40,
   parameter int unsigned SHIFT = DEF_SHIFT,
   parameter int unsigned OUT_W = DEF_OUT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p_valid,
   input  logic             p_last,
   input  logic [P_W-1:0]   p,
   output logic [OUT_W-1:0] y,
   output logic             y_valid,
   output logic             y_sat
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] hold;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] sum;
   logic                    first;
   logic                    frame_ovf;
   logic                    hold_ovf;
   logic                    dump;
   logic                    ovf_now;
   sat_res_t                add_res;
   logic                    unused_sum_hi;

   // The first product of a frame starts from zero and drops the previous
   // frame's sticky overflow.
   always_comb begin
      base    = first ? '0 : acc;
      add_res = sat_add(64'(base), 64'($signed(p)), ACC_W);
      sum     = add_res.sum[ACC_W-1:0];
      ovf_now = add_res.ovf | (~first & frame_ovf);
   end

   // Bits above ACC_W are only sign copies after the clamp.
   assign unused_sum_hi = ^add_res.sum[SAT_W-1:ACC_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         first     <= 1'b1;
         frame_ovf <= 1'b0;
         hold      <= '0;
         hold_ovf  <= 1'b0;
         dump      <= 1'b0;
      end else begin
         dump <= 1'b0;
         if (p_valid) begin
            acc       <= sum;
            frame_ovf <= ovf_now;
            first     <= p_last;
            if (p_last) begin
               hold     <= sum;
               hold_ovf <= ovf_now;
               dump     <= 1'b1;
            end
         end
      end
   end

   round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .hold_ovf (hold_ovf),
      .dump     (dump),
      .y        (y),
      .y_valid  (y_valid),
      .y_sat    (y_sat)
   );

endmodule

// File: tb/tb_mult_product_accum.sv
// Self-checking bench for mult_product_accum: table of one-product frames,
// hand-written multi-cycle sequences and randomized frames, all checked
// against a plain-arithmetic frame model with a result queue.
module tb_mult_product_accum;

   localparam longint ACC_MAX = (64'sd1 <<< 39) - 1;
   localparam longint ACC_MIN = -(64'sd1 <<< 39);
   localparam longint OUT_MAX = 131071;
   localparam longint OUT_MIN = -131072;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p_valid = 1'b0;
   logic        p_last = 1'b0;
   logic [35:0] p = '0;
   logic [17:0] y;
   logic        y_valid;
   logic        y_sat;

   mult_product_accum #(
      .P_W   (36),
      .ACC_W (40),
      .SHIFT (17),
      .OUT_W (18)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .p_valid (p_valid),
      .p_last  (p_last),
      .p       (p),
      .y       (y),
      .y_valid (y_valid),
      .y_sat   (y_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     cyc;
      longint y;
      bit     sat;
   } exp_t;

   typedef struct {
      longint p;
      longint y;
      bit     sat;
   } vec_t;

   exp_t   expq[$];
   int     cyc = 0;
   int     total = 0;
   int     bad = 0;
   // frame model
   longint m_acc = 0;
   bit     m_first = 1'b1;
   bit     m_ovf = 1'b0;
   longint last_y = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   // One clock edge: drive inputs, sample DUT outputs 1 time unit after the
   // edge, then advance the model with what the edge sampled.
   task automatic step(input bit r, input bit v, input bit l, input longint pv,
                       input bit use_exp, input longint ey, input bit es);
      bit     due;
      longint s, rr, yy;
      bit     o, fo, cl;
      rst = r; p_valid = v; p_last = l; p = 36'(pv);
      @(posedge clk);
      #1;
      cyc++;
      if (r) expq.delete();
      due = (expq.size() != 0) && (expq[0].cyc == cyc);
      chk("y_valid", longint'(y_valid), longint'(due));
      if (due) begin
         last_y = expq[0].y;
         chk("y_sat", longint'(y_sat), longint'(expq[0].sat));
         void'(expq.pop_front());
      end
      if (r) last_y = 0;
      chk("y", longint'($signed(y)), last_y);
      if (r) begin
         m_acc = 0; m_first = 1'b1; m_ovf = 1'b0;
      end else if (v) begin
         s = (m_first ? 0 : m_acc) + pv;
         o = 1'b0;
         if (s > ACC_MAX) begin s = ACC_MAX; o = 1'b1; end
         if (s < ACC_MIN) begin s = ACC_MIN; o = 1'b1; end
         fo = (m_first ? 1'b0 : m_ovf) | o;
         m_acc = s; m_ovf = fo; m_first = l;
         if (l) begin
            rr = (s + 65536) >>> 17;
            cl = (rr > OUT_MAX) || (rr < OUT_MIN);
            yy = (rr > OUT_MAX) ? OUT_MAX : (rr < OUT_MIN) ? OUT_MIN : rr;
            if (use_exp) expq.push_back('{cyc + 1, ey, es});
            else         expq.push_back('{cyc + 1, yy, fo | cl});
         end
      end
   endtask

   task automatic prod(input bit l, input longint pv);
      step(1'b0, 1'b1, l, pv, 1'b0, 0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   vec_t   tbl[10];
   longint rp;
   int     len;

   initial begin
      tbl[0] = '{65536, 1, 1'b0};
      tbl[1] = '{-65536, 0, 1'b0};
      tbl[2] = '{-65537, -1, 1'b0};
      tbl[3] = '{65535, 0, 1'b0};
      tbl[4] = '{0, 0, 1'b0};
      tbl[5] = '{(64'sd1 <<< 35) - 1, 131071, 1'b1};
      tbl[6] = '{-(64'sd1 <<< 35), -131072, 1'b1};
      tbl[7] = '{64'sd131071 <<< 17, 131071, 1'b0};
      tbl[8] = '{-(64'sd131072 <<< 17), -131072, 1'b0};
      tbl[9] = '{(64'sd131071 <<< 17) + 65536, 131071, 1'b1};

      // reset state
      step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 12345, 1'b0, 0, 1'b0);
      chk("rst_y_sat", longint'(y_sat), 0);

      // 0.5 x 0.5 single-product frame
      prod(1'b1, 64'sd1 <<< 32);
      chk("exp_32768", expq[0].y, 32768);
      idle(2);

      // back-to-back one-product frames from the table
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b1, 1'b1, tbl[i].p, 1'b1, tbl[i].y, tbl[i].sat);
      idle(3);

      // four products with a 3-cycle gap after the second
      prod(1'b0, 64'sd1 <<< 32);
      prod(1'b0, 64'sd1 <<< 32);
      idle(3);
      prod(1'b0, 64'sd1 <<< 32);
      step(1'b0, 1'b1, 1'b1, 64'sd1 <<< 32, 1'b1, 131071, 1'b1);
      idle(2);

      // accumulator saturation then a clean frame
      for (int i = 0; i < 31; i++) prod(1'b0, 64'sd1 <<< 34);
      step(1'b0, 1'b1, 1'b1, 64'sd1 <<< 34, 1'b1, 131071, 1'b1);
      step(1'b0, 1'b1, 1'b1, 64'sd1 <<< 17, 1'b1, 1, 1'b0);
      idle(2);

      // reset mid-frame discards the partial sum
      prod(1'b0, 64'sd1 <<< 33);
      prod(1'b0, 64'sd1 <<< 33);
      prod(1'b0, 64'sd1 <<< 33);
      step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, 1'b1, -(64'sd1 <<< 32), 1'b1, -32768, 1'b0);
      idle(2);

      // last without valid is ignored
      prod(1'b0, 64'sd1 <<< 32);
      step(1'b0, 1'b0, 1'b1, 64'sd1 <<< 34, 1'b0, 0, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 1'b1, 64'sd1 <<< 32, 1'b1, 65536, 1'b0);
      idle(2);

      // randomized frames
      for (int f = 0; f < 60; f++) begin
         len = int'($urandom_range(1, 6));
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               rp = longint'($signed(36'({$urandom, $urandom})));
               step(1'b0, 1'b0, $urandom_range(0, 1) == 1, rp, 1'b0, 0, 1'b0);
            end
            if (f % 3 == 0)
               rp = longint'($signed(36'({$urandom, $urandom})));
            else
               rp = longint'($urandom_range(0, 1 << 22)) - (64'sd1 <<< 21);
            prod(k == len - 1, rp);
         end
      end
      idle(3);

      chk("queue_empty", longint'(expq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_product_accum.md
Name: mult_product_accum

Overview:
- Downstream consumer of the 2-stage pipelined 18x18 signed multiplier. Takes its 36-bit product stream and accumulates products over a frame delimited by a last flag.
- Dumps each frame sum through a round/shift/saturate stage and emits one 18-bit result per frame.
- Sits between the multiplier and the FIR/decimator output register in the receive DSP chain.

Parameters:
- P_W, 36, product width; must match the multiplier output.
- ACC_W, 40, accumulator width; P_W plus 4 guard bits, giving 16 full-scale products without wrap.
- SHIFT, 17, right shift applied to the frame sum before saturation; Q17 x Q17 product back to Q17. Range 1..ACC_W-OUT_W.
- OUT_W, 18, result width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p_valid  in  1  product on p is valid this cycle; the driver aligns it to multiplier latency.
- p_last  in  1  qualifies the final product of a frame; ignored when p_valid=0.
- p  in  P_W  signed product.
- y  out  OUT_W  signed rounded/saturated frame result; holds between updates.
- y_valid  out  1  one-cycle pulse when y is updated.
- y_sat  out  1  valid with y_valid; 1 if the output clamp or accumulator saturation hit this frame.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - acc=0, first=1, frame_ovf=0, hold=0, hold_ovf=0, dump=0.
  - y=0, y_valid=0, y_sat=0.
  - Reset mid-frame discards the partial sum; no y_valid for that frame.
- Accumulate stage, at each edge with p_valid=1:
  - sum = (first ? 0 : acc) + sign_extend(p, ACC_W).
  - If the signed add overflows, clamp sum to +2^(ACC_W-1)-1 or -2^(ACC_W-1) per operand signs, and set frame_ovf. frame_ovf is sticky within the frame; a frame's first product clears the old value.
  - acc <= clamped sum.
  - If p_last: hold <= clamped sum, hold_ovf <= frame_ovf including this cycle, dump <= 1, first <= 1. Otherwise first <= 0, dump <= 0.
- p_valid=0: acc, first and frame_ovf hold; dump <= 0. Gaps inside a frame are allowed.
- Output stage, at the edge after dump=1:
  - r = (hold + 2^(SHIFT-1)) >>> SHIFT; arithmetic shift, round-half-up. Pre-add is done at ACC_W+1 bits so it cannot wrap.
  - y <= clamp(r, -2^(OUT_W-1), 2^(OUT_W-1)-1).
  - y_sat <= hold_ovf | (r outside range).
  - y_valid <= 1 for one cycle, otherwise 0.
- Latency:
  - Edge E0 samples p_valid&p_last.
  - y_valid is high in the cycle following edge E1 = E0+1.
  - Total: 2 edges from last product to result.
- Throughput: one-product frames on consecutive cycles give y_valid every cycle. A new frame starting on the cycle after a last is legal with no bubble.
- Simultaneous events:
  - rst has priority over p_valid.
  - A single-product frame (first=1 and p_last) sets hold = sign_extend(p).

Decomposition:
- Shared package dsp_pkg holds:
  - constants MULT_W=36 and MULT_LAT=2, used by the driver to delay valid/last;
  - the default OUT_W and SHIFT;
  - function sat_add(a, b) returning the clamped sum plus an overflow bit.
- One sub-module, round_sat: registered round-half-up, shift and clamp (hold, hold_ovf, dump -> y, y_sat, y_valid), parameterised by ACC_W, SHIFT and OUT_W. Reused by other decimator outputs.

Test Plan:
- Reset then a single frame with p=2^32 (0.5x0.5 in Q17) and p_last=1 -> y_valid exactly 2 edges later, y=32768, y_sat=0.
- Rounding, three one-product frames p=65536, -65536, -65537 on back-to-back cycles -> y=1, 0, -1 on three consecutive y_valid pulses.
- Four-product frame of 2^32 each, with a 3-cycle p_valid gap after product 2 -> y=131071 (clamped from 131072), y_sat=1.
- Accumulator saturation: 32 products of 2^34 -> frame_ovf set, y=131071, y_sat=1. Next frame of one product p=2^17 -> y=1, y_sat=0 (sticky flag cleared).
- Reset mid-frame after 3 products, then a one-product frame p=-2^32 -> only one y_valid, y=-32768. No stale sum carried over.
- p_last=1 with p_valid=0 -> ignored: no y_valid, acc unchanged. The following real last produces the correct sum.
